// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling tick: mid-bit sampling,
// LSB-first reassembly, one-cycle done / framing-error strobes.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 br_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_sync_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (br_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            bit_d  = '0;
            // A line that is high again at mid start bit was only a glitch.
            state_d = rx_sync_q ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (br_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (br_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            bit_d  = '0;
            if (rx_sync_q) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = BRK;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      // A held-low line must go high before another start can be seen.
      BRK: begin
        if (rx_sync_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus glitch, break, reset and
// tick-stall sequences; line timing is counted in br_tick pulses.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       br_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int tick_div = 54;
  bit tick_en = 1'b1;
  bit prev_pulse = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         gap;
    logic [7:0] exp_data;
    int         exp_done;
  } vec_t;

  vec_t tbl[4];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .br_tick  (br_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Baud generator model: one-clk tick every tick_div clocks while enabled.
  initial begin
    int cnt;
    cnt = 0;
    br_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en && cnt >= tick_div - 1) begin
        br_tick = 1'b1;
        cnt = 0;
      end else begin
        br_tick = 1'b0;
        if (tick_en) cnt++;
      end
    end
  end

  // Pulse monitor: counts strobes and checks they are single-cycle and exclusive.
  always begin
    @(negedge clk);
    if (rx_done || frame_err) begin
      n_cmp++;
      if ((rx_done && frame_err) || prev_pulse) begin
        n_bad++;
        $display("FAIL pulse_shape: done=%0b err=%0b prev=%0b, required single exclusive pulse",
                 rx_done, frame_err, prev_pulse);
      end
      if (rx_done) done_cnt++;
      if (frame_err) err_cnt++;
    end
    prev_pulse = rx_done || frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      do begin
        @(posedge clk);
        t++;
      end while (!br_tick && t < 200);
      if (!br_tick) begin
        $display("FAIL tick_timeout: no br_tick within %0d clk", t);
        $fatal(1, "tick timeout");
      end
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stall_bit);
    rx = 1'b0;
    wait_ticks(8);
    chk("busy_in_start", rx_busy, 1);
    wait_ticks(8);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == stall_bit) begin
        wait_ticks(5);
        tick_en = 1'b0;
        repeat (1000) @(negedge clk);
        chk("busy_during_stall", rx_busy, 1);
        tick_en = 1'b1;
        wait_ticks(11);
      end else begin
        wait_ticks(16);
      end
    end
    rx = stop;
    wait_ticks(16);
  endtask

  initial begin
    tbl[0] = '{8'h55, 54, 4, 8'h55, 1};
    tbl[1] = '{8'hA3, 6, 0, 8'hA3, 2};
    tbl[2] = '{8'h00, 6, 0, 8'h00, 3};
    tbl[3] = '{8'hFF, 6, 0, 8'hFF, 4};

    rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_done", rx_done, 0);
    chk("reset_rx_busy", rx_busy, 0);
    chk("reset_frame_err", frame_err, 0);
    reset = 1'b0;

    // Frame table; zero gap means the next start bit follows the stop bit directly.
    for (int v = 0; v < 4; v++) begin
      tick_div = tbl[v].div;
      wait_ticks(tbl[v].gap);
      send_frame(tbl[v].data, 1'b1, -1);
      chk("tbl_rx_data", rx_data, tbl[v].exp_data);
      chk("tbl_done_cnt", done_cnt, tbl[v].exp_done);
      chk("tbl_err_cnt", err_cnt, 0);
      chk("tbl_busy_after_stop", rx_busy, 0);
    end

    // Short low glitch on an idle line.
    rx = 1'b0;
    wait_ticks(3);
    chk("glitch_busy", rx_busy, 1);
    rx = 1'b1;
    wait_ticks(16);
    chk("glitch_idle", rx_busy, 0);
    chk("glitch_done_cnt", done_cnt, 4);
    chk("glitch_err_cnt", err_cnt, 0);
    chk("glitch_rx_data", rx_data, 8'hFF);

    // Bad stop bit followed by a long break.
    send_frame(8'h3C, 1'b0, -1);
    chk("ferr_err_cnt", err_cnt, 1);
    chk("ferr_done_cnt", done_cnt, 4);
    chk("ferr_rx_data", rx_data, 8'hFF);
    chk("ferr_busy", rx_busy, 1);
    wait_ticks(320);
    chk("break_busy", rx_busy, 1);
    chk("break_err_cnt", err_cnt, 1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_release_idle", rx_busy, 0);
    wait_ticks(32);
    chk("break_after_err_cnt", err_cnt, 1);
    chk("break_after_done_cnt", done_cnt, 4);

    // Reset in the middle of data bit 4 of 0x81.
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h81 >> i) & 8'h01;
      wait_ticks(16);
    end
    rx = 1'b0;
    wait_ticks(8);
    chk("pre_reset_busy", rx_busy, 1);
    reset = 1'b1;
    rx = 1'b1;
    #1;
    chk("midreset_rx_data", rx_data, 8'h00);
    chk("midreset_busy", rx_busy, 0);
    chk("midreset_done", rx_done, 0);
    chk("midreset_err", frame_err, 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    wait_ticks(20);
    chk("postreset_done_cnt", done_cnt, 4);
    send_frame(8'h7E, 1'b1, -1);
    chk("postreset_rx_data", rx_data, 8'h7E);
    chk("postreset_done_cnt2", done_cnt, 5);
    chk("postreset_err_cnt", err_cnt, 1);

    // br_tick stalled for 1000 clk in the middle of data bit 3.
    wait_ticks(4);
    send_frame(8'hC5, 1'b1, 3);
    chk("stall_rx_data", rx_data, 8'hC5);
    chk("stall_done_cnt", done_cnt, 6);
    chk("stall_err_cnt", err_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
